// File: rtl/lc3_pkg.sv
// Shared LC3 pipeline definitions: memory-stage opcodes, memory FSM state codes.
// Latency: n/a (constants and a pure decode function).
// Backpressure: n/a.
package lc3_pkg;

  // Memory-stage operation codes driven by the controller on mem_state.
  localparam logic [2:0] MEM_RD   = 3'd0;
  localparam logic [2:0] MEM_IND  = 3'd1;
  localparam logic [2:0] MEM_WR   = 3'd2;
  localparam logic [2:0] MEM_IDLE = 3'd3;

  // Memory-access FSM state type and codes.
  typedef logic [2:0] mem_fsm_state_t;

  localparam mem_fsm_state_t ST_IDLE    = 3'd0;
  localparam mem_fsm_state_t ST_RD      = 3'd1;
  localparam mem_fsm_state_t ST_IND_PTR = 3'd2;
  localparam mem_fsm_state_t ST_IND_GAP = 3'd3;
  localparam mem_fsm_state_t ST_IND_RD  = 3'd4;
  localparam mem_fsm_state_t ST_IND_WR  = 3'd5;
  localparam mem_fsm_state_t ST_WR      = 3'd6;
  localparam mem_fsm_state_t ST_DONE    = 3'd7;

  // Default watchdog limit, in cycles of req held without ack.
  localparam int LC3_TIMEOUT_CYCLES = 64;

  // First FSM state for an accepted operation; codes 3..7 map to IDLE (not accepted).
  function automatic mem_fsm_state_t mem_accept_state(input logic [2:0] code);
    case (code)
      MEM_RD:  return ST_RD;
      MEM_IND: return ST_IND_PTR;
      MEM_WR:  return ST_WR;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_fsm_watchdog.sv
// Transaction watchdog: counts cycles a request waits, flags expiry at the limit.
// Latency: expire is combinational from the count register, valid in the last waiting cycle.
// Backpressure: none; only built when MEM_TIMEOUT_EN is defined.
`ifdef MEM_TIMEOUT_EN
module mem_watchdog
  import lc3_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = LC3_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count cycles spent with req high; restart on every new request; saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count 0 is the first req cycle, so LIMIT marks the TIMEOUT_CYCLES-th waiting cycle.
  assign expire = run && (cnt_q == LIMIT);

endmodule
`endif

// File: rtl/mem_access_fsm.sv
// LC3 memory-access stage: runs read, write or indirect (pointer then read/write) ops over DMem req/ack.
// Latency: zero-wait memory gives complete_data 2 cycles after mem_start (4 for indirect ops).
// Backpressure: req held until ack; mem_start ignored while busy. MEM_TIMEOUT_EN adds watchdog + mem_err.
module mem_access_fsm
  import lc3_pkg::*;
#(
  parameter int DATA_W = 16
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = LC3_TIMEOUT_CYCLES
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_start,
  input  logic [2:0]        mem_state,
  input  logic              M_Control,
  input  logic [DATA_W-1:0] M_Addr,
  input  logic [DATA_W-1:0] M_Data,
  input  logic [DATA_W-1:0] DMem_dout,
  input  logic              DMem_ack,
  output logic              DMem_req,
  output logic              DMem_we,
  output logic [DATA_W-1:0] DMem_addr,
  output logic [DATA_W-1:0] DMem_din,
  output logic [DATA_W-1:0] memout,
  output logic              complete_data,
  output logic              busy
`ifdef MEM_TIMEOUT_EN
  ,
  output logic              mem_err
`endif
);

  mem_fsm_state_t state_q, state_d;

  logic              req_q,      req_d;
  logic              we_q,       we_d;
  logic [DATA_W-1:0] addr_q,     addr_d;
  logic [DATA_W-1:0] din_q,      din_d;
  logic [DATA_W-1:0] memout_q,   memout_d;
  logic              complete_q, complete_d;
  logic              busy_q,     busy_d;

  // Operands captured at accept; the pointer comes back from the first indirect read.
  logic [DATA_W-1:0] cap_data_q, cap_data_d;
  logic              cap_ctrl_q, cap_ctrl_d;
  logic [DATA_W-1:0] ptr_q,      ptr_d;

  logic wd_expire;

`ifdef MEM_TIMEOUT_EN
  logic err_q, err_d;
  logic wd_clear;

  // Restart the watchdog on each rising req so every phase gets its own budget.
  assign wd_clear = req_d && !req_q;

  mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clear (wd_clear),
    .run   (req_q),
    .expire(wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  // Next-state and registered-output computation for the whole stage.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    din_d      = din_q;
    memout_d   = memout_q;
    complete_d = 1'b0;
    cap_data_d = cap_data_q;
    cap_ctrl_d = cap_ctrl_q;
    ptr_d      = ptr_q;
`ifdef MEM_TIMEOUT_EN
    err_d      = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (mem_start) begin
          state_d = mem_accept_state(mem_state);
          if (state_d != ST_IDLE) begin
            cap_data_d = M_Data;
            cap_ctrl_d = M_Control;
            req_d      = 1'b1;
            addr_d     = M_Addr;
            we_d       = (state_d == ST_WR);
            din_d      = (state_d == ST_WR) ? M_Data : '0;
          end
        end
      end

      ST_RD, ST_IND_RD: begin
        if (DMem_ack) begin
          memout_d   = DMem_dout;
          state_d    = ST_DONE;
          complete_d = 1'b1;
          req_d      = 1'b0;
          we_d       = 1'b0;
          addr_d     = '0;
          din_d      = '0;
        end
      end

      ST_WR, ST_IND_WR: begin
        if (DMem_ack) begin
          state_d    = ST_DONE;
          complete_d = 1'b1;
          req_d      = 1'b0;
          we_d       = 1'b0;
          addr_d     = '0;
          din_d      = '0;
        end
      end

      ST_IND_PTR: begin
        if (DMem_ack) begin
          ptr_d   = DMem_dout;
          state_d = ST_IND_GAP;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          din_d   = '0;
        end
      end

      // One req-low cycle between the pointer read and the second access.
      ST_IND_GAP: begin
        state_d = cap_ctrl_q ? ST_IND_WR : ST_IND_RD;
        req_d   = 1'b1;
        addr_d  = ptr_q;
        we_d    = cap_ctrl_q;
        din_d   = cap_ctrl_q ? cap_data_q : '0;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        din_d   = '0;
      end
    endcase

`ifdef MEM_TIMEOUT_EN
    // Watchdog abort overrides the phase logic, including any remaining indirect phase.
    if (req_q && !DMem_ack && wd_expire) begin
      state_d    = ST_DONE;
      complete_d = 1'b1;
      err_d      = 1'b1;
      memout_d   = memout_q;
      req_d      = 1'b0;
      we_d       = 1'b0;
      addr_d     = '0;
      din_d      = '0;
    end
`endif

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      memout_q   <= '0;
      complete_q <= 1'b0;
      busy_q     <= 1'b0;
      cap_data_q <= '0;
      cap_ctrl_q <= 1'b0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      memout_q   <= memout_d;
      complete_q <= complete_d;
      busy_q     <= busy_d;
      cap_data_q <= cap_data_d;
      cap_ctrl_q <= cap_ctrl_d;
      ptr_q      <= ptr_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Error flag register, pulses alongside complete_data on a watchdog abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign mem_err = err_q;
`endif

  assign DMem_req      = req_q;
  assign DMem_we       = we_q;
  assign DMem_addr     = addr_q;
  assign DMem_din      = din_q;
  assign memout        = memout_q;
  assign complete_data = complete_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mem_access_fsm.sv
// Directed bench for mem_access_fsm: each task drives one scenario and checks cycle by cycle.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
// Define MEM_TIMEOUT_EN to include the watchdog scenario.
module tb_mem_access_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_start;
  logic [2:0]  mem_state;
  logic        M_Control;
  logic [15:0] M_Addr;
  logic [15:0] M_Data;
  logic [15:0] DMem_dout;
  logic        DMem_ack;
  logic        DMem_req;
  logic        DMem_we;
  logic [15:0] DMem_addr;
  logic [15:0] DMem_din;
  logic [15:0] memout;
  logic        complete_data;
  logic        busy;
`ifdef MEM_TIMEOUT_EN
  logic        mem_err;
`endif

  int errors = 0;
  int checks = 0;

  logic [33:0] bus;

  mem_access_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .mem_start    (mem_start),
    .mem_state    (mem_state),
    .M_Control    (M_Control),
    .M_Addr       (M_Addr),
    .M_Data       (M_Data),
    .DMem_dout    (DMem_dout),
    .DMem_ack     (DMem_ack),
    .DMem_req     (DMem_req),
    .DMem_we      (DMem_we),
    .DMem_addr    (DMem_addr),
    .DMem_din     (DMem_din),
    .memout       (memout),
    .complete_data(complete_data),
    .busy         (busy)
`ifdef MEM_TIMEOUT_EN
    ,
    .mem_err      (mem_err)
`endif
  );

  always #5 clk = ~clk;

  assign bus = {DMem_req, DMem_we, DMem_addr, DMem_din};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    mem_start = 1'b0;
    mem_state = 3'd3;
    M_Control = 1'b0;
    M_Addr    = 16'h0000;
    M_Data    = 16'h0000;
    DMem_ack  = 1'b0;
    DMem_dout = 16'h0000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_start = 1'b1; mem_state = 3'd0; M_Addr = 16'h1234; M_Data = 16'h5678;
    DMem_ack = 1'b1; DMem_dout = 16'hFFFF;
    step(); step();
    checks++;
    if ({bus, memout, complete_data, busy} !== 52'h0) begin
      errors++;
      $display("FAIL reset_outputs got bus=%h memout=%h cmp=%b busy=%b exp all zero",
               bus, memout, complete_data, busy);
    end
`ifdef MEM_TIMEOUT_EN
    checks++;
    if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_mem_err got=%b exp=0", mem_err); end
`endif
    rst = 1'b0;
    quiet_inputs();
    step();
  endtask

  task automatic test_ld();
    mem_start = 1'b1; mem_state = 3'd0; M_Addr = 16'h3000;
    step();
    mem_start = 1'b0;
    checks++;
    if (bus !== {1'b1, 1'b0, 16'h3000, 16'h0000}) begin
      errors++; $display("FAIL ld_req_cycle1 got=%h exp=%h", bus, {1'b1, 1'b0, 16'h3000, 16'h0000});
    end
    DMem_ack = 1'b1; DMem_dout = 16'hBEEF;
    step();
    DMem_ack = 1'b0;
    checks++;
    if ({complete_data, busy, DMem_req, memout} !== {1'b1, 1'b1, 1'b0, 16'hBEEF}) begin
      errors++; $display("FAIL ld_done_cycle2 got cmp=%b busy=%b req=%b memout=%h exp 1 1 0 beef",
                         complete_data, busy, DMem_req, memout);
    end
    step();
    checks++;
    if ({complete_data, busy} !== 2'b00) begin
      errors++; $display("FAIL ld_idle_cycle3 got cmp=%b busy=%b exp 0 0", complete_data, busy);
    end
  endtask

  task automatic test_st_wait();
    int pulses;
    pulses = 0;
    mem_start = 1'b1; mem_state = 3'd2; M_Addr = 16'h3010; M_Data = 16'h1234;
    step();
    mem_start = 1'b0; M_Data = 16'h0000;
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (bus !== {1'b1, 1'b1, 16'h3010, 16'h1234}) begin
        errors++; $display("FAIL st_hold_cycle%0d got=%h exp=%h", c, bus, {1'b1, 1'b1, 16'h3010, 16'h1234});
      end
      if (complete_data === 1'b1) pulses++;
      DMem_ack = (c == 4);
      step();
    end
    DMem_ack = 1'b0;
    checks++;
    if ({complete_data, DMem_req, memout} !== {1'b1, 1'b0, 16'hBEEF}) begin
      errors++; $display("FAIL st_done got cmp=%b req=%b memout=%h exp 1 0 beef",
                         complete_data, DMem_req, memout);
    end
    if (complete_data === 1'b1) pulses++;
    step();
    if (complete_data === 1'b1) pulses++;
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL st_pulse_count got=%0d exp=1", pulses); end
  endtask

  task automatic test_ldi();
    mem_start = 1'b1; mem_state = 3'd1; M_Control = 1'b0; M_Addr = 16'h3020;
    step();
    mem_start = 1'b0;
    checks++;
    if (bus !== {1'b1, 1'b0, 16'h3020, 16'h0000}) begin
      errors++; $display("FAIL ldi_ptr_req got=%h exp=%h", bus, {1'b1, 1'b0, 16'h3020, 16'h0000});
    end
    DMem_ack = 1'b1; DMem_dout = 16'h4000;
    step();
    // Spurious ack during the gap cycle must be ignored.
    DMem_ack = 1'b1; DMem_dout = 16'hDEAD;
    checks++;
    if ({DMem_req, busy, complete_data} !== 3'b010) begin
      errors++; $display("FAIL ldi_gap got req=%b busy=%b cmp=%b exp 0 1 0", DMem_req, busy, complete_data);
    end
    step();
    checks++;
    if (bus !== {1'b1, 1'b0, 16'h4000, 16'h0000}) begin
      errors++; $display("FAIL ldi_data_req got=%h exp=%h", bus, {1'b1, 1'b0, 16'h4000, 16'h0000});
    end
    DMem_ack = 1'b1; DMem_dout = 16'h00AA;
    step();
    DMem_ack = 1'b0;
    checks++;
    if ({complete_data, memout} !== {1'b1, 16'h00AA}) begin
      errors++; $display("FAIL ldi_done_cycle4 got cmp=%b memout=%h exp 1 00aa", complete_data, memout);
    end
    step();
  endtask

  task automatic test_sti();
    mem_start = 1'b1; mem_state = 3'd1; M_Control = 1'b1; M_Addr = 16'h3030; M_Data = 16'h7777;
    step();
    mem_start = 1'b0; M_Control = 1'b0; M_Data = 16'h0000;
    checks++;
    if (bus !== {1'b1, 1'b0, 16'h3030, 16'h0000}) begin
      errors++; $display("FAIL sti_ptr_req got=%h exp=%h", bus, {1'b1, 1'b0, 16'h3030, 16'h0000});
    end
    DMem_ack = 1'b1; DMem_dout = 16'h5000;
    step();
    DMem_ack = 1'b0;
    step();
    checks++;
    if (bus !== {1'b1, 1'b1, 16'h5000, 16'h7777}) begin
      errors++; $display("FAIL sti_write_req got=%h exp=%h", bus, {1'b1, 1'b1, 16'h5000, 16'h7777});
    end
    DMem_ack = 1'b1;
    step();
    DMem_ack = 1'b0;
    checks++;
    if ({complete_data, memout} !== {1'b1, 16'h00AA}) begin
      errors++; $display("FAIL sti_done got cmp=%b memout=%h exp 1 00aa", complete_data, memout);
    end
    step();
  endtask

  task automatic test_ignored();
    logic [2:0] codes [2];
    codes[0] = 3'd3;
    codes[1] = 3'd7;
    for (int i = 0; i < 2; i++) begin
      mem_start = 1'b1; mem_state = codes[i]; M_Addr = 16'h0F0F;
      step();
      mem_start = 1'b0;
      step();
      checks++;
      if ({DMem_req, busy, complete_data} !== 3'b000) begin
        errors++; $display("FAIL ignore_code%0d got req=%b busy=%b cmp=%b exp 0 0 0",
                           codes[i], DMem_req, busy, complete_data);
      end
    end
    DMem_ack = 1'b1; DMem_dout = 16'hDEAD;
    step();
    DMem_ack = 1'b0;
    checks++;
    if ({DMem_req, complete_data, memout} !== {1'b0, 1'b0, 16'h00AA}) begin
      errors++; $display("FAIL idle_ack got req=%b cmp=%b memout=%h exp 0 0 00aa",
                         DMem_req, complete_data, memout);
    end
    // Load at the top of the address space, with a second start while busy.
    mem_start = 1'b1; mem_state = 3'd0; M_Addr = 16'hFFFF;
    step();
    mem_state = 3'd2; M_Addr = 16'h1111; M_Data = 16'h2222;
    step();
    mem_start = 1'b0;
    checks++;
    if (bus !== {1'b1, 1'b0, 16'hFFFF, 16'h0000}) begin
      errors++; $display("FAIL busy_start got=%h exp=%h", bus, {1'b1, 1'b0, 16'hFFFF, 16'h0000});
    end
    DMem_ack = 1'b1; DMem_dout = 16'h5A5A;
    step();
    DMem_ack = 1'b0;
    checks++;
    if ({complete_data, memout} !== {1'b1, 16'h5A5A}) begin
      errors++; $display("FAIL ffff_done got cmp=%b memout=%h exp 1 5a5a", complete_data, memout);
    end
    mem_start = 1'b1; mem_state = 3'd0; M_Addr = 16'h2222;
    step();
    mem_start = 1'b0;
    checks++;
    if ({DMem_req, busy, complete_data} !== 3'b000) begin
      errors++; $display("FAIL done_start got req=%b busy=%b cmp=%b exp 0 0 0", DMem_req, busy, complete_data);
    end
    step();
    checks++;
    if ({DMem_req, busy} !== 2'b00) begin
      errors++; $display("FAIL no_queue got req=%b busy=%b exp 0 0", DMem_req, busy);
    end
  endtask

  task automatic test_back_to_back();
    mem_start = 1'b1; mem_state = 3'd0; M_Addr = 16'h0100;
    step();
    mem_start = 1'b0; DMem_ack = 1'b1; DMem_dout = 16'h1111;
    step();
    DMem_ack = 1'b0;
    step();
    mem_start = 1'b1; mem_state = 3'd2; M_Addr = 16'h0200; M_Data = 16'h2222;
    step();
    mem_start = 1'b0;
    checks++;
    if (bus !== {1'b1, 1'b1, 16'h0200, 16'h2222}) begin
      errors++; $display("FAIL b2b_st_req got=%h exp=%h", bus, {1'b1, 1'b1, 16'h0200, 16'h2222});
    end
    DMem_ack = 1'b1;
    step();
    DMem_ack = 1'b0;
    checks++;
    if ({complete_data, memout} !== {1'b1, 16'h1111}) begin
      errors++; $display("FAIL b2b_done got cmp=%b memout=%h exp 1 1111", complete_data, memout);
    end
    step();
  endtask

  task automatic test_rst_mid();
    mem_start = 1'b1; mem_state = 3'd1; M_Control = 1'b0; M_Addr = 16'h3040;
    step();
    mem_start = 1'b0; DMem_ack = 1'b1; DMem_dout = 16'h6000;
    step();
    DMem_ack = 1'b0;
    step();
    checks++;
    if (bus !== {1'b1, 1'b0, 16'h6000, 16'h0000}) begin
      errors++; $display("FAIL rst_mid_ind_rd got=%h exp=%h", bus, {1'b1, 1'b0, 16'h6000, 16'h0000});
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({DMem_req, busy, complete_data, memout} !== {3'b000, 16'h0000}) begin
      errors++; $display("FAIL rst_mid_abort got req=%b busy=%b cmp=%b memout=%h exp 0 0 0 0000",
                         DMem_req, busy, complete_data, memout);
    end
    DMem_ack = 1'b1; DMem_dout = 16'h9999;
    step();
    DMem_ack = 1'b0;
    checks++;
    if ({DMem_req, busy, complete_data, memout} !== {3'b000, 16'h0000}) begin
      errors++; $display("FAIL late_ack got req=%b busy=%b cmp=%b memout=%h exp 0 0 0 0000",
                         DMem_req, busy, complete_data, memout);
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    mem_start = 1'b1; mem_state = 3'd0; M_Addr = 16'h0ABC;
    step();
    mem_start = 1'b0;
    for (int c = 1; c < 64; c++) step();
    checks++;
    if ({DMem_req, complete_data, mem_err} !== 3'b100) begin
      errors++; $display("FAIL timeout_cycle64 got req=%b cmp=%b err=%b exp 1 0 0",
                         DMem_req, complete_data, mem_err);
    end
    step();
    checks++;
    if ({DMem_req, complete_data, mem_err, memout} !== {3'b011, 16'h0000}) begin
      errors++; $display("FAIL timeout_abort got req=%b cmp=%b err=%b memout=%h exp 0 1 1 0000",
                         DMem_req, complete_data, mem_err, memout);
    end
    step();
    checks++;
    if ({busy, complete_data, mem_err} !== 3'b000) begin
      errors++; $display("FAIL timeout_idle got busy=%b cmp=%b err=%b exp 0 0 0", busy, complete_data, mem_err);
    end
  endtask
`endif

  initial begin
    quiet_inputs();
    rst = 1'b1;
    test_reset();
    test_ld();
    test_st_wait();
    test_ldi();
    test_sti();
    test_ignored();
    test_back_to_back();
    test_rst_mid();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
